// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Definitions shared by the APB master and slave interface blocks.
//   ST_*      : bit index of each state in the one-hot state vector
//   ST_W      : width of the one-hot state vector
//   PPROT_*   : bit positions inside PPROT
//   apb_state_e : one-hot transfer state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int ST_IDLE   = 0;
   localparam int ST_SETUP  = 1;
   localparam int ST_ACCESS = 2;
   localparam int ST_RESP   = 3;
   localparam int ST_W      = 4;

   localparam int PPROT_PRIV   = 0;
   localparam int PPROT_NONSEC = 1;
   localparam int PPROT_INSTR  = 2;

   typedef enum logic [ST_W-1:0] {
      S_IDLE   = ST_W'(1 << ST_IDLE),
      S_SETUP  = ST_W'(1 << ST_SETUP),
      S_ACCESS = ST_W'(1 << ST_ACCESS),
      S_RESP   = ST_W'(1 << ST_RESP)
   } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS wait cycles and flags when the limit is reached.
// Ports:
//   apb_clk_in  : clock (posedge)
//   apb_rstn_in : asynchronous active-low reset, counter cleared to 0
//   clr         : synchronous clear (asserted during SETUP)
//   inc         : count one wait cycle
//   expired     : counter equals TIMEOUT_CYCLE
// -----------------------------------------------------------------------------
module apb_wait_timer #(
   parameter int TIMEOUT_CYCLE = 16
) (
   input  logic apb_clk_in,
   input  logic apb_rstn_in,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYCLE + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLE);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !expired) begin
         // Saturates at the limit so a stalled FSM cannot wrap it.
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/apb_master_if.sv
// -----------------------------------------------------------------------------
// apb_master_if
// APB initiator: takes one local request at a time over valid/ready and runs
// it as an APB SETUP/ACCESS transfer, returning a one-cycle response pulse.
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLE
// wait cycles with an error response).
// Ports:
//   apb_clk_in, apb_rstn_in          : clock, async active-low reset
//   req_valid_in / req_ready_out     : request handshake
//   req_addr_in, req_write_in, req_wdata_in, req_strb_in, req_prot_in
//                                    : request fields, sampled on accept
//   rsp_valid_out                    : one-cycle response pulse
//   rsp_rdata_out, rsp_err_out       : response data/error, held until next
//   apb_psel_out, apb_penable_out, apb_addr_out, apb_write_out,
//   apb_wdata_out, apb_strb_out, apb_prot_out : APB request side
//   apb_rdata_in, apb_ready_in, apb_slverr_in : APB completion side
// -----------------------------------------------------------------------------
module apb_master_if
   import apb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLE  = 16
) (
   input  logic                        apb_clk_in,
   input  logic                        apb_rstn_in,
   input  logic                        req_valid_in,
   output logic                        req_ready_out,
   input  logic [APB_ADDR_WIDTH-1:0]   req_addr_in,
   input  logic                        req_write_in,
   input  logic [APB_DATA_WIDTH-1:0]   req_wdata_in,
   input  logic [APB_DATA_WIDTH/8-1:0] req_strb_in,
   input  logic [2:0]                  req_prot_in,
   output logic                        rsp_valid_out,
   output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
   output logic                        rsp_err_out,
   output logic                        apb_psel_out,
   output logic                        apb_penable_out,
   output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
   output logic                        apb_write_out,
   output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
   output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
   output logic [2:0]                  apb_prot_out,
   input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
   input  logic                        apb_ready_in,
   input  logic                        apb_slverr_in
);

   generate
      if ((APB_DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLE < 1) begin : g_bad_param
         $error("apb_master_if: APB_DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLE >= 1");
      end
   endgenerate

   apb_state_e state;

`ifdef APB_TIMEOUT_EN
   logic tmr_expired;

   apb_wait_timer #(
      .TIMEOUT_CYCLE (TIMEOUT_CYCLE)
   ) u_wait_timer (
      .apb_clk_in  (apb_clk_in),
      .apb_rstn_in (apb_rstn_in),
      .clr         (state == S_SETUP),
      .inc         ((state == S_ACCESS) && !apb_ready_in),
      .expired     (tmr_expired)
   );
`endif

   // req_ready_out is a register: it reads 0 in reset and rises on the first
   // clock in IDLE, so a request can only be accepted once ready is visible.
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         state           <= S_IDLE;
         req_ready_out   <= 1'b0;
         rsp_valid_out   <= 1'b0;
         rsp_rdata_out   <= '0;
         rsp_err_out     <= 1'b0;
         apb_psel_out    <= 1'b0;
         apb_penable_out <= 1'b0;
         apb_addr_out    <= '0;
         apb_write_out   <= 1'b0;
         apb_wdata_out   <= '0;
         apb_strb_out    <= '0;
         apb_prot_out    <= '0;
      end else begin
         rsp_valid_out <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid_in && req_ready_out) begin
                  apb_addr_out  <= req_addr_in;
                  apb_write_out <= req_write_in;
                  apb_wdata_out <= req_wdata_in;
                  apb_strb_out  <= req_write_in ? req_strb_in : '0;
                  apb_prot_out  <= {req_prot_in[PPROT_INSTR],
                                    req_prot_in[PPROT_NONSEC],
                                    req_prot_in[PPROT_PRIV]};
                  apb_psel_out  <= 1'b1;
                  req_ready_out <= 1'b0;
                  state         <= S_SETUP;
               end else begin
                  req_ready_out <= 1'b1;
               end
            end
            S_SETUP: begin
               apb_penable_out <= 1'b1;
               state           <= S_ACCESS;
            end
            S_ACCESS: begin
               // PREADY takes priority over an expiring timer.
               if (apb_ready_in) begin
                  apb_psel_out    <= 1'b0;
                  apb_penable_out <= 1'b0;
                  rsp_valid_out   <= 1'b1;
                  rsp_err_out     <= apb_slverr_in;
                  rsp_rdata_out   <= (!apb_write_out && !apb_slverr_in) ? apb_rdata_in : '0;
                  state           <= S_RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (tmr_expired) begin
                  apb_psel_out    <= 1'b0;
                  apb_penable_out <= 1'b0;
                  rsp_valid_out   <= 1'b1;
                  rsp_err_out     <= 1'b1;
                  rsp_rdata_out   <= '0;
                  state           <= S_RESP;
               end
`endif
            end
            S_RESP: begin
               req_ready_out <= 1'b1;
               state         <= S_IDLE;
            end
            default: begin
               apb_psel_out    <= 1'b0;
               apb_penable_out <= 1'b0;
               req_ready_out   <= 1'b0;
               state           <= S_IDLE;
            end
         endcase
      end
   end

endmodule
